rx_state_trace_buffer: RTL

Parametrised successor to the single-word decoder state-history register. It records every receiver FSM state transition, with a timestamp, into a DEPTH-entry ring buffer. It supports continuous ring capture, or freeze-on-trigger capture with a programmable post-trigger window. Triggers are FCS failure, watchdog reset, or software. It sits beside the dot11 core in the rx top level; software drains it through a pop/valid readout port mapped onto AXI-lite status registers.

---
 rtl/rx_state_trace_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rx_state_trace_buffer.sv
// Receiver FSM transition trace: timestamped ring buffer with
// continuous or freeze-on-trigger capture and a FWFT readout port.
module rx_state_trace_buffer #(
  parameter int STATE_WIDTH = 5,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH_LOG2  = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [STATE_WIDTH-1:0]            state_in,
  input  logic                              fcs_out_strobe,
  input  logic                              fcs_ok,
  input  logic                              watchdog_rst,
  input  logic                              sw_trigger,
  input  logic                              trig_fcs_en,
  input  logic                              trig_wdog_en,
  input  logic                              freeze_mode,
  input  logic [DEPTH_LOG2-1:0]             post_trig_len,
  input  logic                              rearm,
  input  logic                              rd_pop,
  output logic [TS_WIDTH+2*STATE_WIDTH-1:0] rd_data,
  output logic                              rd_valid,
  output logic [DEPTH_LOG2:0]               entry_count,
  output logic                              frozen,
  output logic                              overflow,
  output logic [15:0]                       trig_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int EW    = TS_WIDTH + 2 * STATE_WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST_TRIG,
    FROZEN
  } fsm_t;

  fsm_t                   fsm;
  logic [TS_WIDTH-1:0]    ts;
  logic [STATE_WIDTH-1:0] prev_state;
  logic [EW-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  post_cnt;

  logic change;
  logic trig;
  logic capture;
  logic wr;
  logic pop;
  logic empty;
  logic full;

  assign change  = state_in != prev_state;
  assign trig    = (trig_fcs_en & fcs_out_strobe & ~fcs_ok)
                 | (trig_wdog_en & watchdog_rst)
                 | sw_trigger;
  assign capture = (fsm == ARMED) || (fsm == POST_TRIG);
  assign wr      = capture & change & enable & ~rearm;
  assign empty   = entry_count == '0;
  assign full    = entry_count == FULL;
  assign pop     = rd_pop & ~empty & ~rearm;

  assign rd_valid = ~empty;
  assign frozen   = fsm == FROZEN;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      ts         <= '0;
      prev_state <= '0;
    end else begin
      ts         <= ts + TS_WIDTH'(1);
      prev_state <= state_in;
    end
  end

  always_ff @(posedge clock) begin
    if (wr && !reset) begin
      mem[wr_ptr] <= {ts, prev_state, state_in};
    end
  end

  // A full buffer advances the head on every write, whether the
  // slot is freed by a pop or lost to an overwrite.
  always_ff @(posedge clock) begin
    if (reset || rearm) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (wr && empty) begin
        entry_count <= CNT_ONE;
      end else if (wr && full) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (!pop) begin
          overflow <= 1'b1;
        end
      end else if (wr) begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end else begin
          entry_count <= entry_count + CNT_ONE;
        end
      end else if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        entry_count <= entry_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm        <= IDLE;
      post_cnt   <= '0;
      trig_count <= '0;
    end else begin
      if (trig && fsm != IDLE && trig_count != 16'hFFFF) begin
        trig_count <= trig_count + 16'd1;
      end
      if (rearm) begin
        fsm      <= enable ? ARMED : IDLE;
        post_cnt <= '0;
      end else if (!enable) begin
        fsm <= IDLE;
      end else begin
        unique case (fsm)
          IDLE: fsm <= ARMED;
          ARMED: begin
            // a same-cycle change is stored as a pre-trigger entry
            if (freeze_mode && trig) begin
              post_cnt <= post_trig_len;
              fsm      <= (post_trig_len == '0) ? FROZEN : POST_TRIG;
            end
          end
          POST_TRIG: begin
            if (wr) begin
              post_cnt <= post_cnt - PTR_ONE;
              if (post_cnt == PTR_ONE) begin
                fsm <= FROZEN;
              end
            end
          end
          FROZEN: fsm <= FROZEN;
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule
